rr_grant_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource (e.g. a single priority-encoder/datapath instance) among N_REQ requesters.
- Issues a registered one-hot grant and its binary index. Holds the grant until the owner signals done, drops its request, or exceeds a hold budget.
- After each release, priority rotates to the index above the previous owner.
- Sits between requester front-ends and the shared datapath's valid/data mux.

---
 rtl/rr_grant_arbiter.sv | 120 ++++++++++++
 tb/tb_rr_grant_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin arbiter with hold budget for one shared datapath
module rr_grant_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDX_W    = $clog2(N_REQ)
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             done_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_val_o,
    output logic             preempt_o
);

    localparam int HC_W = $clog2(MAX_HOLD + 2);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [HC_W-1:0]  hold_cnt, hold_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             preempt_nxt;

    logic [IDX_W-1:0] owner_inc;
    logic [IDX_W-1:0] arb_ptr;
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] pick;
    logic [N_REQ-1:0] win_oh;
    logic [IDX_W-1:0] win_idx;
    logic             owner_req;
    logic             budget_hit;
    logic             release_now;

    assign owner_inc   = (grant_idx_o == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_o + IDX_W'(1);
    assign owner_req   = req_i[grant_idx_o];
    assign budget_hit  = (MAX_HOLD != 0) && (hold_cnt == HC_W'(MAX_HOLD));
    assign release_now = (state == BUSY) && (done_i || !owner_req || budget_hit);

    // On a release edge the rotated pointer is used immediately so the grant can hand over with no idle gap.
    assign arb_ptr = release_now ? owner_inc : ptr;
    assign masked  = req_i & ({N_REQ{1'b1}} << arb_ptr);
    assign pick    = (|masked) ? masked : req_i;
    assign win_oh  = pick & ~(pick - N_REQ'(1));

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        grant_nxt   = grant_o;
        idx_nxt     = grant_idx_o;
        preempt_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (|req_i) begin
                    grant_nxt = win_oh;
                    idx_nxt   = win_idx;
                    hold_nxt  = HC_W'(1);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_nxt     = owner_inc;
                    preempt_nxt = budget_hit && !done_i && owner_req;
                    if (|req_i) begin
                        grant_nxt = win_oh;
                        idx_nxt   = win_idx;
                        hold_nxt  = HC_W'(1);
                    end else begin
                        grant_nxt = '0;
                        state_nxt = IDLE;
                    end
                end else if (MAX_HOLD != 0) begin
                    hold_nxt = hold_cnt + HC_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant_o     <= '0;
            grant_idx_o <= '0;
            preempt_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            hold_cnt    <= hold_nxt;
            grant_o     <= grant_nxt;
            grant_idx_o <= idx_nxt;
            preempt_o   <= preempt_nxt;
        end
    end

    assign grant_val_o = |grant_o;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - scoreboard bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       arst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] gidx;
    logic       gval;
    logic       pre;

    always #5 clk = ~clk;

    rr_grant_arbiter #(
        .N_REQ(N),
        .MAX_HOLD(MH),
        .IDX_W(2)
    ) dut (
        .clk_i(clk),
        .arst_i(arst),
        .req_i(req),
        .done_i(done),
        .grant_o(grant),
        .grant_idx_o(gidx),
        .grant_val_o(gval),
        .preempt_o(pre)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] i;
        logic       v;
        logic       p;
    } exp_t;

    exp_t sb_q[$];

    bit         m_busy;
    int         m_ptr;
    int         m_hold;
    int         m_idx;
    logic [3:0] m_grant;
    bit         m_pre;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int find_win(input logic [3:0] r, input int p);
        for (int off = 0; off < N; off++) begin
            if (r[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_ptr   = 0;
        m_hold  = 0;
        m_idx   = 0;
        m_grant = '0;
        m_pre   = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic d);
        int  w;
        bit  budget;
        m_pre = 0;
        if (m_busy) begin
            budget = (m_hold == MH);
            if (d || !r[m_idx] || budget) begin
                m_pre = budget && !d && r[m_idx];
                m_ptr = (m_idx + 1) % N;
                w = find_win(r, m_ptr);
                if (w >= 0) begin
                    m_grant = 4'(1 << w);
                    m_idx   = w;
                    m_hold  = 1;
                end else begin
                    m_grant = '0;
                    m_busy  = 0;
                end
            end else if (m_hold < MH) begin
                m_hold++;
            end
        end else begin
            w = find_win(r, m_ptr);
            if (w >= 0) begin
                m_grant = 4'(1 << w);
                m_idx   = w;
                m_hold  = 1;
                m_busy  = 1;
            end
        end
    endtask

    task automatic cycle(input logic [3:0] r, input logic d, input string tag);
        exp_t e;
        req  = r;
        done = d;
        model_step(r, d);
        e.g = m_grant;
        e.i = 2'(m_idx);
        e.v = |m_grant;
        e.p = m_pre;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_grant"}, 32'(grant), 32'(e.g));
            check_eq({tag, "_idx"}, 32'(gidx), 32'(e.i));
            check_eq({tag, "_val"}, 32'(gval), 32'(e.v));
            check_eq({tag, "_pre"}, 32'(pre), 32'(e.p));
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        arst = 1'b1;
        #1;
        check_eq({tag, "_rst_grant"}, 32'(grant), 32'd0);
        check_eq({tag, "_rst_idx"}, 32'(gidx), 32'd0);
        check_eq({tag, "_rst_val"}, 32'(gval), 32'd0);
        check_eq({tag, "_rst_pre"}, 32'(pre), 32'd0);
        model_reset();
        @(negedge clk);
        arst = 1'b0;
    endtask

    logic [3:0] t2_seq [5];

    initial begin
        arst = 1'b1;
        req  = '0;
        done = 1'b0;
        model_reset();
        #2;
        check_eq("init_grant", 32'(grant), 32'd0);
        check_eq("init_val", 32'(gval), 32'd0);
        @(negedge clk);
        arst = 1'b0;

        // 1: first grant latency
        cycle(4'b1010, 1'b0, "t1");
        check_eq("t1_const_grant", 32'(grant), 32'h2);
        check_eq("t1_const_idx", 32'(gidx), 32'd1);

        // 2: full rotation with done every grant cycle
        do_reset("t2");
        t2_seq[0] = 4'b0001;
        t2_seq[1] = 4'b0010;
        t2_seq[2] = 4'b0100;
        t2_seq[3] = 4'b1000;
        t2_seq[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 1'b1, "t2");
            check_eq($sformatf("t2_const_%0d", i), 32'(grant), 32'(t2_seq[i]));
        end

        // 3: hold budget preemption between two requesters
        do_reset("t3");
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0011, 1'b0, "t3");
            check_eq($sformatf("t3_hold_%0d", i), 32'(grant), 32'h1);
        end
        cycle(4'b0011, 1'b0, "t3");
        check_eq("t3_switch", 32'(grant), 32'h2);
        check_eq("t3_preempt", 32'(pre), 32'd1);
        cycle(4'b0011, 1'b0, "t3");
        check_eq("t3_preempt_end", 32'(pre), 32'd0);

        // 4: sole requester re-granted across budget boundary
        for (int i = 0; i < 12; i++) begin
            cycle(4'b0001, 1'b0, "t4");
            check_eq("t4_val", 32'(gval), 32'd1);
        end

        // 5: pointer wrap then idle
        cycle(4'b0100, 1'b1, "t5");
        check_eq("t5_owner2", 32'(grant), 32'h4);
        cycle(4'b1100, 1'b1, "t5");
        check_eq("t5_owner3", 32'(grant), 32'h8);
        cycle(4'b0101, 1'b1, "t5");
        check_eq("t5_wrap", 32'(gidx), 32'd0);
        cycle(4'b0000, 1'b0, "t5");
        check_eq("t5_idle_grant", 32'(grant), 32'd0);
        check_eq("t5_idle_idx", 32'(gidx), 32'd0);
        cycle(4'b0000, 1'b1, "t5");

        // random traffic
        for (int i = 0; i < 300; i++) begin
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), "rnd");
        end

        // 6: async reset mid-grant, then ptr restarts at 0
        cycle(4'b0010, 1'b0, "t6");
        do_reset("t6");
        cycle(4'b1100, 1'b0, "t6");
        check_eq("t6_const_grant", 32'(grant), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
